// File: rtl/shift_frame_ctrl.sv
// Serial frame receiver: synchronizes data_in, samples on bit_tick, and hands frames
// over a valid/ready slot. Define SHIFT_FRAME_CTRL_PARITY_EN to add an even-parity bit.
module shift_frame_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_in,
  input  logic              bit_tick,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef SHIFT_FRAME_CTRL_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  shift_reg;
  logic               sync_a, sync_b, sync_c;
  logic               start_edge;
  logic               shift_en, cnt_clr, deliver, err;
  logic               accept;

  assign start_edge = ~sync_b & sync_c;
  assign busy       = (state != IDLE);
  assign accept     = deliver & (~frame_valid | frame_ready);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    deliver  = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_n = START;
      end
      START: begin
        if (bit_tick) begin
          if (!sync_b) begin
            state_n = DATA;
            cnt_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef SHIFT_FRAME_CTRL_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          if ((^shift_reg) ^ sync_b) begin
            err     = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (sync_b) deliver = 1'b1;
          else        err     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_reg   <= '0;
      sync_a      <= 1'b1;
      sync_b      <= 1'b1;
      sync_c      <= 1'b1;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sync_a    <= data_in;
      sync_b    <= sync_a;
      sync_c    <= sync_b;
      state     <= state_n;
      overrun   <= deliver & frame_valid & ~frame_ready;
      frame_err <= err;

      if (cnt_clr)       cnt <= '0;
      else if (shift_en) cnt <= cnt + CNT_W'(1);

      if (shift_en) shift_reg <= {sync_b, shift_reg[DATA_W-1:1]};

      // A delivery on a handshake edge refills the slot instead of emptying it.
      if (accept) begin
        frame_data  <= shift_reg;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
